// File: rtl/node_frame_sequencer.sv
// Frame sequencer for a chain of simulation nodes.
// It drives one Verlet strobe and FIX_ITERS constraint strobes, snapshots every node's x/y
// position, and then streams the snapshot out one node per beat over valid/ready.
module node_frame_sequencer #(
   parameter int unsigned NUM_NODES = 8,
   parameter int unsigned FIX_ITERS = 3,
   parameter int unsigned IDX_W     = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   frame_tick,
   input  logic [8*NUM_NODES-1:0] node_x_bus,
   input  logic [8*NUM_NODES-1:0] node_y_bus,
   output logic                   verlet_state,
   output logic                   fix_constraint_state,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [IDX_W-1:0]       out_idx,
   output logic [7:0]             out_x,
   output logic [7:0]             out_y,
   output logic                   out_last,
   output logic                   frame_done,
   output logic                   busy,
   output logic                   overrun
);

   typedef enum logic [2:0] {
      StIdle,
      StVerlet,
      StFix,
      StSnap,
      StStream,
      StDone
   } state_t;

   state_t                 state_q;
   logic [3:0]             iter_q;
   logic [8*NUM_NODES-1:0] snap_x_q;
   logic [8*NUM_NODES-1:0] snap_y_q;
   logic [IDX_W-1:0]       idx_next;
   logic [IDX_W+2:0]       sel_next;

   // Index of the beat that follows the current one, and its bit offset into the snapshot.
   always_comb begin
      idx_next = out_idx + IDX_W'(1);
      sel_next = {idx_next, 3'b000};
   end

   // Frame FSM. Every output is a register that is set on the edge that enters its state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q              <= StIdle;
         iter_q               <= '0;
         snap_x_q             <= '0;
         snap_y_q             <= '0;
         verlet_state         <= 1'b0;
         fix_constraint_state <= 1'b0;
         out_valid            <= 1'b0;
         out_idx              <= '0;
         out_x                <= '0;
         out_y                <= '0;
         out_last             <= 1'b0;
         frame_done           <= 1'b0;
         busy                 <= 1'b0;
         overrun              <= 1'b0;
      end else begin
         // A tick that arrives while a frame is in flight is dropped and only flagged.
         if (frame_tick && busy) begin
            overrun <= 1'b1;
         end
         unique case (state_q)
            StIdle: begin
               if (frame_tick) begin
                  state_q      <= StVerlet;
                  verlet_state <= 1'b1;
                  busy         <= 1'b1;
               end
            end
            StVerlet: begin
               state_q              <= StFix;
               verlet_state         <= 1'b0;
               fix_constraint_state <= 1'b1;
               iter_q               <= '0;
            end
            StFix: begin
               if (iter_q == 4'(FIX_ITERS - 1)) begin
                  state_q              <= StSnap;
                  fix_constraint_state <= 1'b0;
               end else begin
                  iter_q <= iter_q + 4'd1;
               end
            end
            StSnap: begin
               // The first beat is loaded from the same bus values that the snapshot captures.
               state_q   <= StStream;
               snap_x_q  <= node_x_bus;
               snap_y_q  <= node_y_bus;
               out_valid <= 1'b1;
               out_idx   <= '0;
               out_x     <= node_x_bus[7:0];
               out_y     <= node_y_bus[7:0];
               out_last  <= 1'b0;
            end
            StStream: begin
               if (out_valid && out_ready) begin
                  if (out_idx == IDX_W'(NUM_NODES - 1)) begin
                     state_q    <= StDone;
                     out_valid  <= 1'b0;
                     out_last   <= 1'b0;
                     frame_done <= 1'b1;
                  end else begin
                     out_idx  <= idx_next;
                     out_x    <= snap_x_q[sel_next +: 8];
                     out_y    <= snap_y_q[sel_next +: 8];
                     out_last <= (idx_next == IDX_W'(NUM_NODES - 1));
                  end
               end
            end
            StDone: begin
               state_q    <= StIdle;
               frame_done <= 1'b0;
               busy       <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_node_frame_sequencer.sv
// Self-checking bench for node_frame_sequencer.
// The expected beats are the bus bytes that the bench drove before the snapshot. The expected
// strobe and handshake timing is derived from the frame timeline.
module tb_node_frame_sequencer;

   localparam int N  = 8;
   localparam int F  = 3;
   localparam int IW = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           frame_tick;
   logic [8*N-1:0] node_x_bus;
   logic [8*N-1:0] node_y_bus;
   logic           verlet_state;
   logic           fix_constraint_state;
   logic           out_valid;
   logic           out_ready;
   logic [IW-1:0]  out_idx;
   logic [7:0]     out_x;
   logic [7:0]     out_y;
   logic           out_last;
   logic           frame_done;
   logic           busy;
   logic           overrun;

   int         tests = 0;
   int         fails = 0;
   bit         exp_overrun = 1'b0;
   logic [7:0] ex [N];
   logic [7:0] ey [N];

   always #5 clk = ~clk;

   node_frame_sequencer #(
      .NUM_NODES(N),
      .FIX_ITERS(F),
      .IDX_W    (IW)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .frame_tick          (frame_tick),
      .node_x_bus          (node_x_bus),
      .node_y_bus          (node_y_bus),
      .verlet_state        (verlet_state),
      .fix_constraint_state(fix_constraint_state),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out_idx             (out_idx),
      .out_x               (out_x),
      .out_y               (out_y),
      .out_last            (out_last),
      .frame_done          (frame_done),
      .busy                (busy),
      .overrun             (overrun)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_bus();
      for (int i = 0; i < N; i++) begin
         node_x_bus[8*i +: 8] = ex[i];
         node_y_bus[8*i +: 8] = ey[i];
      end
   endtask

   task automatic rand_bus();
      for (int i = 0; i < N; i++) begin
         ex[i] = 8'($urandom_range(0, 255));
         ey[i] = 8'($urandom_range(0, 255));
      end
      load_bus();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_verlet"}, 32'(verlet_state), 32'd0);
      check({tag, "_fix"},    32'(fix_constraint_state), 32'd0);
      check({tag, "_valid"},  32'(out_valid), 32'd0);
      check({tag, "_idx"},    32'(out_idx), 32'd0);
      check({tag, "_x"},      32'(out_x), 32'd0);
      check({tag, "_y"},      32'(out_y), 32'd0);
      check({tag, "_last"},   32'(out_last), 32'd0);
      check({tag, "_done"},   32'(frame_done), 32'd0);
      check({tag, "_busy"},   32'(busy), 32'd0);
      check({tag, "_ovr"},    32'(overrun), 32'd0);
   endtask

   task automatic idle_check(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         check("idle_verlet", 32'(verlet_state), 32'd0);
         check("idle_valid",  32'(out_valid), 32'd0);
         check("idle_busy",   32'(busy), 32'd0);
         check("idle_ovr",    32'(overrun), 32'(exp_overrun));
      end
   endtask

   // One frame, starting with a tick in the current (idle) cycle. On return, the bench is in
   // the cycle after DONE, where busy has just fallen.
   task automatic run_frame(input int stall_idx, input int stall_len, input bit corrupt,
                            input bit ovr_tick, input bit done_tick, input int abort_at,
                            input bit rand_ready);
      int  beat    = 0;
      int  stalled = 0;
      int  guard   = 0;
      bit  r;
      frame_tick = 1'b1;
      check("tick_busy", 32'(busy), 32'd0);
      step();
      frame_tick = 1'b0;
      check("verlet_on",  32'(verlet_state), 32'd1);
      check("verlet_fix", 32'(fix_constraint_state), 32'd0);
      check("verlet_busy", 32'(busy), 32'd1);
      check("verlet_valid", 32'(out_valid), 32'd0);
      for (int k = 2; k <= F + 1; k++) begin
         step();
         frame_tick = 1'b0;
         check("fix_on",     32'(fix_constraint_state), 32'd1);
         check("fix_verlet", 32'(verlet_state), 32'd0);
         check("fix_valid",  32'(out_valid), 32'd0);
         if (ovr_tick && k == 3) begin
            frame_tick  = 1'b1;
            exp_overrun = 1'b1;
         end
      end
      step();
      frame_tick = 1'b0;
      check("snap_fix",   32'(fix_constraint_state), 32'd0);
      check("snap_valid", 32'(out_valid), 32'd0);
      check("snap_busy",  32'(busy), 32'd1);
      check("snap_ovr",   32'(overrun), 32'(exp_overrun));
      step();
      if (corrupt) begin
         node_x_bus = '1;
         node_y_bus = '1;
      end
      while (beat < N && guard < 200) begin
         if (beat == abort_at) begin
            #2 reset = 1'b1;
            #1 check_zero("async_rst");
            step();
            check_zero("rst_hold");
            reset       = 1'b0;
            exp_overrun = 1'b0;
            step();
            check("rst_no_done", 32'(frame_done), 32'd0);
            check("rst_no_busy", 32'(busy), 32'd0);
            return;
         end
         check("beat_valid", 32'(out_valid), 32'd1);
         check("beat_idx",   32'(out_idx), 32'(beat));
         check("beat_x",     32'(out_x), 32'(ex[beat]));
         check("beat_y",     32'(out_y), 32'(ey[beat]));
         check("beat_last",  32'(out_last), 32'(beat == N - 1));
         check("beat_strobes", 32'({verlet_state, fix_constraint_state}), 32'd0);
         if (beat == stall_idx && stalled < stall_len) begin
            r = 1'b0;
            stalled++;
         end else if (rand_ready) begin
            r = ($urandom_range(0, 3) != 0);
         end else begin
            r = 1'b1;
         end
         out_ready = r;
         step();
         if (r) beat++;
         guard++;
      end
      out_ready = 1'b1;
      check("beat_count", 32'(beat), 32'(N));
      check("done_pulse", 32'(frame_done), 32'd1);
      check("done_valid", 32'(out_valid), 32'd0);
      check("done_busy",  32'(busy), 32'd1);
      if (done_tick) begin
         frame_tick  = 1'b1;
         exp_overrun = 1'b1;
      end
      step();
      frame_tick = 1'b0;
      check("post_done", 32'(frame_done), 32'd0);
      check("post_busy", 32'(busy), 32'd0);
      check("post_verlet", 32'(verlet_state), 32'd0);
      check("post_ovr", 32'(overrun), 32'(exp_overrun));
   endtask

   initial begin
      reset      = 1'b1;
      frame_tick = 1'b0;
      out_ready  = 1'b1;
      node_x_bus = '0;
      node_y_bus = '0;
      #2 check_zero("reset_async");
      step();
      step();
      check_zero("reset_hold");
      reset = 1'b0;
      step();
      check_zero("idle");

      // Directed frame: x = 200, y = 10*(i+1), with ready held high.
      for (int i = 0; i < N; i++) begin
         ex[i] = 8'd200;
         ey[i] = 8'(10 * (i + 1));
      end
      load_bus();
      run_frame(-1, 0, 1'b0, 1'b0, 1'b0, -1, 1'b0);

      // Back-to-back frame with a 5-cycle stall on beat 2.
      rand_bus();
      run_frame(2, 5, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      check("b2b_no_ovr", 32'(overrun), 32'd0);
      idle_check(2);

      // Snapshot isolation: the bus goes to 0xFF right after the capture edge.
      rand_bus();
      run_frame(-1, 0, 1'b1, 1'b0, 1'b0, -1, 1'b0);
      idle_check(2);

      // Overrun: a second tick 3 cycles after the first one.
      rand_bus();
      run_frame(-1, 0, 1'b0, 1'b1, 1'b0, -1, 1'b0);
      idle_check(3);

      // A tick in the DONE cycle is dropped.
      rand_bus();
      run_frame(-1, 0, 1'b0, 1'b0, 1'b1, -1, 1'b1);
      idle_check(3);

      // Asynchronous reset mid-stream, after beat 3, then a clean frame.
      rand_bus();
      run_frame(-1, 0, 1'b0, 1'b0, 1'b0, 4, 1'b0);
      idle_check(2);
      rand_bus();
      run_frame(-1, 0, 1'b0, 1'b0, 1'b0, -1, 1'b0);

      // Random frames with random backpressure.
      for (int f = 0; f < 4; f++) begin
         rand_bus();
         idle_check(1);
         run_frame(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 4)), 1'(f[0]),
                   1'b0, 1'b0, -1, 1'b1);
      end
      check("final_ovr", 32'(overrun), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
